// File: rtl/intc_uprio.sv
// intc_uprio: user-level interrupt controller for the RV32 cores.
// Synchronises NSRC async lines, latches them as pending (edge or level per
// source), masks them, picks the lowest index and raises one request with a
// ucause value. Claim on trap entry, complete on uret.
// Build option: define INTC_NESTED_EN to allow a strictly higher-priority source
// to preempt a handler in service (ids kept on a stack, popped by complete).
module intc_uprio #(
   parameter int unsigned     NSRC       = 8,
   parameter logic [NSRC-1:0] EDGE_MASK  = {NSRC{1'b1}},
   parameter int unsigned     CAUSE_BASE = 16
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic [NSRC-1:0] iIrq,
   input  logic            iUie,
   input  logic            iMaskWe,
   input  logic [NSRC-1:0] iMaskData,
   input  logic            iClaim,
   input  logic            iComplete,
   output logic            oIrqReq,
   output logic [4:0]      oIrqId,
   output logic [31:0]     oCause,
   output logic [NSRC-1:0] oPending,
   output logic [NSRC-1:0] oMask,
   output logic            oBusy
);

   typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

   localparam logic [4:0] CauseLo = 5'(CAUSE_BASE % 32);

   logic [NSRC-1:0] s1_q, s2_q, s3_q;
   logic [NSRC-1:0] pend_q, pend_d, mask_q;
   logic [NSRC-1:0] enabled, id_sel, edge_set, claim_clr;
   state_e          state_q, state_d;
   logic [4:0]      id_q, id_d, win_id, cause_lo;
   logic            win_vld, id_en, claim_fire;

`ifdef INTC_NESTED_EN
   localparam int unsigned DepthW = $clog2(NSRC + 1);
   logic [DepthW-1:0] depth_q, depth_d;
   logic [4:0]        stack_q [NSRC];
   logic [4:0]        stack_d [NSRC];
   logic              preempt;
`endif

   // Two-flop synchroniser plus a delay flop for rising-edge detection.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= iIrq;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Lowest enabled index wins; also decode whether the latched id is still enabled.
   always_comb begin
      enabled = pend_q & mask_q;
      win_vld = 1'b0;
      win_id  = '0;
      id_sel  = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (enabled[i]) begin
            win_vld = 1'b1;
            win_id  = 5'(i);
         end
      end
      for (int i = 0; i < NSRC; i++) begin
         id_sel[i] = (id_q == 5'(i));
      end
      id_en = |(enabled & id_sel);
   end

   // Edge sources: set on rise, clear on claim (set wins); level sources follow s2.
   always_comb begin
      claim_fire = (state_q == StReq) && iClaim;
      edge_set   = s2_q & ~s3_q;
      claim_clr  = {NSRC{claim_fire}} & id_sel & EDGE_MASK;
      pend_d     = (EDGE_MASK & ((pend_q & ~claim_clr) | edge_set)) | (~EDGE_MASK & s2_q);
   end

   // Pending and mask registers.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         pend_q <= '0;
         mask_q <= '0;
      end else begin
         pend_q <= pend_d;
         if (iMaskWe) begin
            mask_q <= iMaskData;
         end
      end
   end

   // Request/service FSM next state, latched id and (optionally) the nesting stack.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
`ifdef INTC_NESTED_EN
      depth_d = depth_q;
      stack_d = stack_q;
      preempt = iUie && win_vld && (win_id < id_q);
`endif
      unique case (state_q)
         StIdle: begin
            if (iUie && win_vld) begin
               state_d = StReq;
               id_d    = win_id;
            end
         end
         StReq: begin
            if (iClaim) begin
               state_d = StService;
`ifdef INTC_NESTED_EN
               stack_d[0] = id_q;
               for (int i = 1; i < NSRC; i++) begin
                  stack_d[i] = stack_q[i-1];
               end
               depth_d = depth_q + 1'b1;
`endif
            end else if (!iUie || !id_en) begin
`ifdef INTC_NESTED_EN
               // A withdrawn preemption falls back to the handler already running.
               if (depth_q != '0) begin
                  state_d = StService;
                  id_d    = stack_q[0];
               end else begin
                  state_d = StIdle;
               end
`else
               state_d = StIdle;
`endif
            end
         end
         StService: begin
            if (iComplete) begin
`ifdef INTC_NESTED_EN
               for (int i = 0; i < NSRC - 1; i++) begin
                  stack_d[i] = stack_q[i+1];
               end
               stack_d[NSRC-1] = '0;
               depth_d         = depth_q - 1'b1;
               if (depth_q == DepthW'(1)) begin
                  state_d = StIdle;
               end else begin
                  id_d = stack_q[1];
               end
`else
               state_d = StIdle;
`endif
            end
`ifdef INTC_NESTED_EN
            else if (preempt) begin
               state_d = StReq;
               id_d    = win_id;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state, id and stack registers.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= StIdle;
         id_q    <= '0;
`ifdef INTC_NESTED_EN
         depth_q <= '0;
         for (int i = 0; i < NSRC; i++) begin
            stack_q[i] <= '0;
         end
`endif
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
`ifdef INTC_NESTED_EN
         depth_q <= depth_d;
         stack_q <= stack_d;
`endif
      end
   end

   // Outputs; the cause code wraps modulo 32.
   always_comb begin
      cause_lo = CauseLo + id_q;
      oIrqReq  = (state_q == StReq);
      oIrqId   = id_q;
      oCause   = {1'b1, 26'b0, cause_lo};
      oPending = pend_q;
      oMask    = mask_q;
`ifdef INTC_NESTED_EN
      oBusy    = (depth_q != '0);
`else
      oBusy    = (state_q == StService);
`endif
   end

endmodule

// File: tb/tb_intc_uprio.sv
// Bench for intc_uprio: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the controller.
module tb_intc_uprio;

   localparam logic [7:0] EDGE = 8'hFE;
`ifdef INTC_NESTED_EN
   localparam bit Nested = 1'b1;
`else
   localparam bit Nested = 1'b0;
`endif

   logic        iCLK = 1'b0;
   logic        iRST;
   logic [7:0]  iIrq;
   logic        iUie;
   logic        iMaskWe;
   logic [7:0]  iMaskData;
   logic        iClaim;
   logic        iComplete;
   logic        oIrqReq;
   logic [4:0]  oIrqId;
   logic [31:0] oCause;
   logic [7:0]  oPending;
   logic [7:0]  oMask;
   logic        oBusy;

   int checks = 0;
   int failures = 0;

   // Reference model state: samples of the raw lines (newest first),
   // pending/mask vectors, mode (0 idle, 1 requesting, 2 in service), id, stack.
   logic [7:0] hist [$];
   logic [7:0] m_pend, m_mask;
   int         m_st;
   logic [4:0] m_id;
   int         stk [$];

   intc_uprio #(
      .NSRC      (8),
      .EDGE_MASK (EDGE),
      .CAUSE_BASE(16)
   ) dut (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .iIrq     (iIrq),
      .iUie     (iUie),
      .iMaskWe  (iMaskWe),
      .iMaskData(iMaskData),
      .iClaim   (iClaim),
      .iComplete(iComplete),
      .oIrqReq  (oIrqReq),
      .oIrqId   (oIrqId),
      .oCause   (oCause),
      .oPending (oPending),
      .oMask    (oMask),
      .oBusy    (oBusy)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist = '{8'h00, 8'h00, 8'h00};
      m_pend = '0;
      m_mask = '0;
      m_st   = 0;
      m_id   = '0;
      stk.delete();
   endtask

   // One clock edge of the controller's rules, using the inputs present at the edge.
   task automatic model_step();
      logic [7:0] en, s2, s3, nxt;
      int win;
      en  = m_pend & m_mask;
      win = -1;
      for (int i = 7; i >= 0; i--) if (en[i]) win = i;
      s2 = hist[1];
      s3 = hist[2];
      for (int i = 0; i < 8; i++) begin
         if (EDGE[i])
            nxt[i] = (m_pend[i] && !(m_st == 1 && iClaim && int'(m_id) == i)) || (s2[i] && !s3[i]);
         else
            nxt[i] = s2[i];
      end
      case (m_st)
         0: begin
            if (iUie && win >= 0) begin
               m_st = 1;
               m_id = 5'(win);
            end
         end
         1: begin
            if (iClaim) begin
               if (Nested) stk.push_front(int'(m_id));
               m_st = 2;
            end else if (!iUie || !en[m_id[2:0]]) begin
               if (Nested && stk.size() > 0) begin
                  m_st = 2;
                  m_id = 5'(stk[0]);
               end else begin
                  m_st = 0;
               end
            end
         end
         default: begin
            if (iComplete) begin
               if (Nested) begin
                  void'(stk.pop_front());
                  if (stk.size() == 0) m_st = 0;
                  else m_id = 5'(stk[0]);
               end else begin
                  m_st = 0;
               end
            end else if (Nested && iUie && win >= 0 && win < int'(m_id)) begin
               m_st = 1;
               m_id = 5'(win);
            end
         end
      endcase
      m_pend = nxt;
      if (iMaskWe) m_mask = iMaskData;
      hist.push_front(iIrq);
      void'(hist.pop_back());
   endtask

   task automatic cmp_all();
      logic m_busy;
      m_busy = Nested ? (stk.size() != 0) : (m_st == 2);
      chk("req",   32'(oIrqReq),  32'(m_st == 1));
      chk("id",    32'(oIrqId),   32'(m_id));
      chk("cause", oCause,        32'h8000_0000 | 32'((16 + int'(m_id)) % 32));
      chk("pend",  32'(oPending), 32'(m_pend));
      chk("mask",  32'(oMask),    32'(m_mask));
      chk("busy",  32'(oBusy),    32'(m_busy));
   endtask

   task automatic cyc();
      @(posedge iCLK);
      model_step();
      #1;
      cmp_all();
   endtask

   task automatic cycs(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   initial begin
      iRST = 1'b1;
      iIrq = '0;
      iUie = 1'b0;
      iMaskWe = 1'b0;
      iMaskData = '0;
      iClaim = 1'b0;
      iComplete = 1'b0;
      model_reset();
      repeat (2) @(posedge iCLK);
      #1;
      cmp_all();
      chk("rst_cause", oCause, 32'h8000_0010);
      chk("rst_busy", 32'(oBusy), 32'd0);
      iRST = 1'b0;

      // Unmask everything, enable interrupts.
      iMaskWe = 1'b1;
      iMaskData = 8'hFF;
      cyc();
      iMaskWe = 1'b0;
      iUie = 1'b1;
      cyc();

      // Single-cycle pulse on line 3.
      iIrq = 8'h08;
      cyc();
      iIrq = 8'h00;
      cycs(2);
      chk("t1_pend3", 32'(oPending[3]), 32'd1);
      chk("t1_noreq", 32'(oIrqReq), 32'd0);
      cyc();
      chk("t1_req", 32'(oIrqReq), 32'd1);
      chk("t1_id", 32'(oIrqId), 32'd3);
      chk("t1_cause", oCause, 32'h8000_0013);
      iClaim = 1'b1;
      cyc();
      iClaim = 1'b0;
      chk("t1_clr", 32'(oPending[3]), 32'd0);
      chk("t1_busy", 32'(oBusy), 32'd1);
      iComplete = 1'b1;
      cyc();
      iComplete = 1'b0;
      cycs(2);
      chk("t1_norereq", 32'(oIrqReq), 32'd0);

      // Lines 5 and 2 together: 2 first, then 5.
      iIrq = 8'h24;
      cyc();
      iIrq = 8'h00;
      cycs(3);
      chk("t2_id2", 32'(oIrqId), 32'd2);
      iClaim = 1'b1;
      cyc();
      iClaim = 1'b0;
      iComplete = 1'b1;
      cyc();
      iComplete = 1'b0;
      cyc();
      chk("t2_req5", 32'(oIrqReq), 32'd1);
      chk("t2_id5", 32'(oIrqId), 32'd5);
      chk("t2_cause5", oCause, 32'h8000_0015);
      iClaim = 1'b1;
      cyc();
      iClaim = 1'b0;
      iComplete = 1'b1;
      cyc();
      iComplete = 1'b0;
      cyc();

      // Level line 0 held high: re-request after complete.
      iIrq = 8'h01;
      cycs(4);
      chk("t3_id0", 32'(oIrqId), 32'd0);
      iClaim = 1'b1;
      cyc();
      iClaim = 1'b0;
      chk("t3_lvl_kept", 32'(oPending[0]), 32'd1);
      iComplete = 1'b1;
      cyc();
      iComplete = 1'b0;
      cyc();
      chk("t3_rereq", 32'(oIrqReq), 32'd1);
      iClaim = 1'b1;
      cyc();
      iClaim = 1'b0;
      iIrq = 8'h00;
      cycs(3);
      chk("t3_lvl_drop", 32'(oPending[0]), 32'd0);
      iComplete = 1'b1;
      cyc();
      iComplete = 1'b0;
      cycs(2);
      chk("t3_noreq", 32'(oIrqReq), 32'd0);

      // Withdrawal by dropping the global enable.
      iIrq = 8'h10;
      cyc();
      iIrq = 8'h00;
      cycs(3);
      chk("t4_req4", 32'(oIrqReq), 32'd1);
      iUie = 1'b0;
      cyc();
      chk("t4_withdrawn", 32'(oIrqReq), 32'd0);
      iUie = 1'b1;
      cyc();
      chk("t4_rereq", 32'(oIrqReq), 32'd1);
      chk("t4_id4", 32'(oIrqId), 32'd4);
      iClaim = 1'b1;
      cyc();
      iClaim = 1'b0;
      iComplete = 1'b1;
      cyc();
      iComplete = 1'b0;
      cyc();

      // New edge on line 6 lands on the same edge that claims id 6: set wins.
      iIrq = 8'h40;
      cyc();
      iIrq = 8'h00;
      cycs(2);
      iIrq = 8'h40;
      cyc();
      chk("t5_req6", 32'(oIrqId), 32'd6);
      iIrq = 8'h00;
      cyc();
      iClaim = 1'b1;
      cyc();
      iClaim = 1'b0;
      chk("t5_setwins", 32'(oPending[6]), 32'd1);
      chk("t5_busy", 32'(oBusy), 32'd1);

      // Asynchronous reset in the middle of service.
      #1;
      iRST = 1'b1;
      #1;
      model_reset();
      cmp_all();
      chk("t5_rst_busy", 32'(oBusy), 32'd0);
      chk("t5_rst_pend", 32'(oPending), 32'd0);
      chk("t5_rst_cause", oCause, 32'h8000_0010);
      #1;
      iRST = 1'b0;
      iMaskWe = 1'b1;
      iMaskData = 8'hFF;
      cyc();
      iMaskWe = 1'b0;
      cycs(3);
      chk("t5_no_resume", 32'(oIrqReq), 32'd0);

      // Higher-priority source while id 5 is in service.
      iIrq = 8'h20;
      cyc();
      iIrq = 8'h00;
      cycs(3);
      iClaim = 1'b1;
      cyc();
      iClaim = 1'b0;
      iIrq = 8'h02;
      cyc();
      iIrq = 8'h00;
      cycs(3);
      if (Nested) begin
         chk("t6_preempt_req", 32'(oIrqReq), 32'd1);
         chk("t6_preempt_busy", 32'(oBusy), 32'd1);
         chk("t6_preempt_id", 32'(oIrqId), 32'd1);
         iClaim = 1'b1;
         cyc();
         iClaim = 1'b0;
         iComplete = 1'b1;
         cyc();
         chk("t6_back_id5", 32'(oIrqId), 32'd5);
         chk("t6_back_busy", 32'(oBusy), 32'd1);
         cyc();
         iComplete = 1'b0;
         chk("t6_idle", 32'(oBusy), 32'd0);
      end else begin
         chk("t6_no_preempt", 32'(oIrqReq), 32'd0);
         chk("t6_still_busy", 32'(oBusy), 32'd1);
         iComplete = 1'b1;
         cyc();
         iComplete = 1'b0;
         cyc();
         chk("t6_after_req", 32'(oIrqReq), 32'd1);
         chk("t6_after_id", 32'(oIrqId), 32'd1);
         iClaim = 1'b1;
         cyc();
         iClaim = 1'b0;
         iComplete = 1'b1;
         cyc();
         iComplete = 1'b0;
      end
      cycs(2);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         iIrq      = 8'($urandom) & 8'($urandom) & 8'($urandom);
         iUie      = ($urandom_range(0, 9) != 0);
         iMaskWe   = ($urandom_range(0, 19) == 0);
         iMaskData = 8'($urandom);
         iClaim    = ($urandom_range(0, 2) == 0);
         iComplete = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
